wb_sram_bank_ctrl: RTL and testbench
====================================

# wb_sram_bank_ctrl

Wishbone-slave controller for a parametrised array of sky130 OpenRAM 1 kB macros (32 x 256, 1RW + 1R ports), sitting inside the user project wrapper between the management SoC Wishbone bus and up to four macro instances.
- Port 0 gives proper classic-Wishbone reads and writes: address decode, bank select, byte masks, a one-cycle read wait and a registered ack.
- Port 1 is an independent read-only port with a req/valid handshake, intended for logic-analyzer or user-logic access.
- A write/read collision guard protects port 1 from OpenRAM's undefined same-address read-during-write.

## Interface
Parameters:
- BANKS, default 2: number of macros attached; legal range 1..4.
- BASE_ADDR, default 32'h3000_0000: byte base of the 4 kB window; bits [11:0] must be 0.

Ports:
- wb_clk_i  in  1  sole clock; clocks the controller and all macros.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe and write-enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data, registered.
- rd1_req_i  in  1  port-1 read request, single-cycle pulse.
- rd1_addr_i  in  10  {bank[1:0], word[7:0]}.
- rd1_busy_o  out  1  port 1 cannot accept a request.
- rd1_valid_o  out  1  one-cycle data-valid pulse.
- rd1_data_o  out  32  port-1 read data, held until the next valid.
- sram_csb0_o  out  BANKS  per-bank port-0 chip select, active-low.
- sram_web0_o  out  1  shared port-0 write enable, active-low.
- sram_wmask0_o  out  4  shared port-0 byte mask.
- sram_addr0_o  out  8  shared port-0 word address.
- sram_din0_o  out  32  shared port-0 write data.
- sram_dout0_i  in  32*BANKS  port-0 read data; bank b occupies [32b+31:32b].
- sram_csb1_o  out  BANKS  per-bank port-1 chip select, active-low.
- sram_addr1_o  out  8  shared port-1 word address.
- sram_dout1_i  in  32*BANKS  port-1 read data; bank b occupies [32b+31:32b].

## Operation
Address decode:
- Hit when wbs_adr_i[31:12] == BASE_ADDR[31:12].
- Bank = adr[11:10], word = adr[9:2]; adr[1:0] is ignored.
- Bank >= BANKS is a "void" access: no csb is asserted, the access is still acked, reads return 0 and writes are dropped.
- Non-hit accesses are never acked; the block stays in IDLE.

Port 0 FSM has states IDLE, RDWAIT and ACK:
- IDLE with cyc & stb & hit: drive sram_csb0_o[bank]=0 combinationally in this cycle, together with addr0 = word, web0 = ~we, wmask0 = sel and din0 = dat_i.
  - Write: go to ACK.
  - Read: go to RDWAIT.
- RDWAIT: all csb0 high; capture sram_dout0_i[bank] (or 0 for a void bank) into wbs_dat_o; go to ACK.
- ACK: wbs_ack_o=1 for exactly one cycle; go to IDLE.
- If cyc drops in RDWAIT or ACK, the FSM returns to IDLE with no ack. A write already issued stays committed.
- Outside an IDLE issue cycle, sram_csb0_o stays all-ones and sram_web0_o stays 1.

Port 1 FSM has states P1IDLE, P1PEND, P1WAIT and P1DONE:
- P1IDLE with rd1_req_i: latch the address.
  - A collision occurs when port 0 issues a write this cycle to the same bank and word. On collision, go to P1PEND.
  - Otherwise assert sram_csb1_o[bank]=0 this cycle and go to P1WAIT.
- P1PEND: issue csb1 and go to P1WAIT. Port 0 cannot write in this cycle because it is not in IDLE.
- P1WAIT: capture sram_dout1_i[bank] (0 if void) into rd1_data_o; go to P1DONE.
- P1DONE: rd1_valid_o=1; go to P1IDLE.
- rd1_busy_o = (state != P1IDLE). A rd1_req_i while busy is ignored.
- Port-1 reads to a different word during a port-0 write proceed normally.

Reset: all outputs take these values asynchronously and both FSMs return to idle, including mid-transaction.
- wbs_ack_o = 0; wbs_dat_o = 0.
- rd1_busy_o = 0; rd1_valid_o = 0; rd1_data_o = 0.
- sram_csb0_o and sram_csb1_o all ones; sram_web0_o = 1.
- sram_wmask0_o, sram_addr0_o, sram_din0_o and sram_addr1_o = 0.

## Timing
- Request cycle = cycle 0.
- Port 0:
  - Write: ack in cycle 1.
  - Read: ack and data in cycle 2.
  - A master that keeps stb high after ack starts a new access in the next IDLE cycle, so back-to-back reads run every 3 cycles and writes every 2.
- Port 1:
  - Normal read: valid in cycle 2.
  - Collided read: valid in cycle 3.
  - busy is high from cycle 1 through the valid cycle.
- Macro model: inputs sampled at the clock edge ending the issue cycle; dout stable by the end of the following cycle.

## Test plan
- Write 0xDEADBEEF to 0x3000_0404 with sel=4'hF, then read it back -> ack in cycle 1 for the write; bank 1 word 1 shows csb0[1]=0; the read returns 0xDEADBEEF with ack in cycle 2.
- Write 0x11223344 with sel=4'hF, then write 0xAABBCCDD with sel=4'b0101 to the same word, then read -> 0x11BB33DD.
- With BANKS=2, read 0x3000_0C00 -> ack with 0 and no csb asserted; access 0x3001_0000 -> no ack within 10 cycles.
- Port-1 read of {2'd0, 8'h05} in the same cycle as a port-0 write of 0x5 to word 5 bank 0 -> deferred one cycle; rd1_data_o=0x5 with valid in cycle 3; busy high for cycles 1-3.
- Drop cyc in RDWAIT -> no ack, FSM idle the next cycle, and the next read completes normally.
- Assert wb_rst_ni=0 in RDWAIT and P1WAIT -> all outputs take their reset values immediately, with no ack and no valid after release.

Source files
------------

// File: rtl/wb_sram_bank_ctrl_if.sv
// Wishbone slave bus bundle for wb_sram_bank_ctrl; signal names match the
// original flat port list so the wrapper hookup stays one-to-one.
interface wb_sram_bank_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_bank_ctrl.sv
// Wishbone slave + independent read-only port in front of up to four
// OpenRAM 32x256 1RW/1R macros, with a same-word write/read collision guard.
module wb_sram_bank_ctrl #(
  parameter int unsigned BANKS     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  wb_sram_bank_ctrl_if.slave    wbs,
  input  logic                  rd1_req_i,
  input  logic [9:0]            rd1_addr_i,
  output logic                  rd1_busy_o,
  output logic                  rd1_valid_o,
  output logic [31:0]           rd1_data_o,
  output logic [BANKS-1:0]      sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [3:0]            sram_wmask0_o,
  output logic [7:0]            sram_addr0_o,
  output logic [31:0]           sram_din0_o,
  input  logic [32*BANKS-1:0]   sram_dout0_i,
  output logic [BANKS-1:0]      sram_csb1_o,
  output logic [7:0]            sram_addr1_o,
  input  logic [32*BANKS-1:0]   sram_dout1_i
);

  typedef enum logic [1:0] {P0_IDLE, P0_RDWAIT, P0_ACK} p0_state_t;
  typedef enum logic [1:0] {P1_IDLE, P1_PEND, P1_WAIT, P1_DONE} p1_state_t;

  // Banks at or above BANKS have no lane in the bus, so they read as zero.
  function automatic logic [31:0] pick_lane(input logic [32*BANKS-1:0] bus,
                                            input logic [1:0] bk);
    pick_lane = '0;
    for (int unsigned b = 0; b < BANKS; b++)
      if (bk == 2'(b)) pick_lane = bus[32*b +: 32];
  endfunction

  p0_state_t   p0_state;
  logic [1:0]  p0_bank_q;
  logic        p0_hit;
  logic [1:0]  p0_bank;
  logic [7:0]  p0_word;
  logic        p0_issue;
  logic        p0_wr_issue;

  p1_state_t   p1_state;
  logic [1:0]  p1_bank_q;
  logic [7:0]  p1_word_q;
  logic        p1_start;
  logic        p1_collide;
  logic        p1_issue_now;
  logic        p1_issue_pend;
  logic [1:0]  p1_issue_bank;

  assign p0_hit      = (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign p0_bank     = wbs.wbs_adr_i[11:10];
  assign p0_word     = wbs.wbs_adr_i[9:2];
  // Issue terms are gated by reset so the macro strobes go idle the moment
  // reset asserts, not at the next edge.
  assign p0_issue    = wb_rst_ni && (p0_state == P0_IDLE) &&
                       wbs.wbs_cyc_i && wbs.wbs_stb_i && p0_hit;
  assign p0_wr_issue = p0_issue && wbs.wbs_we_i;

  always_comb begin
    sram_csb0_o = '1;
    for (int unsigned b = 0; b < BANKS; b++)
      if (p0_issue && (p0_bank == 2'(b))) sram_csb0_o[b] = 1'b0;
    sram_web0_o   = p0_issue ? ~wbs.wbs_we_i : 1'b1;
    sram_wmask0_o = p0_issue ? wbs.wbs_sel_i : '0;
    sram_addr0_o  = p0_issue ? p0_word       : '0;
    sram_din0_o   = p0_issue ? wbs.wbs_dat_i : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      p0_state      <= P0_IDLE;
      p0_bank_q     <= '0;
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
    end else begin
      case (p0_state)
        P0_IDLE: begin
          wbs.wbs_ack_o <= 1'b0;
          if (p0_issue) begin
            p0_bank_q     <= p0_bank;
            wbs.wbs_ack_o <= wbs.wbs_we_i;
            p0_state      <= wbs.wbs_we_i ? P0_ACK : P0_RDWAIT;
          end
        end
        P0_RDWAIT: begin
          if (!wbs.wbs_cyc_i) begin
            p0_state <= P0_IDLE;
          end else begin
            wbs.wbs_dat_o <= pick_lane(sram_dout0_i, p0_bank_q);
            wbs.wbs_ack_o <= 1'b1;
            p0_state      <= P0_ACK;
          end
        end
        P0_ACK: begin
          wbs.wbs_ack_o <= 1'b0;
          p0_state      <= P0_IDLE;
        end
        default: begin
          wbs.wbs_ack_o <= 1'b0;
          p0_state      <= P0_IDLE;
        end
      endcase
    end
  end

  // A same-word port-0 write would leave the 1R read undefined; defer one
  // cycle, by which point port 0 has left IDLE and cannot write again.
  assign p1_start      = wb_rst_ni && (p1_state == P1_IDLE) && rd1_req_i;
  assign p1_collide    = p0_wr_issue && (p0_bank == rd1_addr_i[9:8]) &&
                         (p0_word == rd1_addr_i[7:0]);
  assign p1_issue_now  = p1_start && !p1_collide;
  assign p1_issue_pend = wb_rst_ni && (p1_state == P1_PEND);
  assign p1_issue_bank = p1_issue_now ? rd1_addr_i[9:8] : p1_bank_q;

  always_comb begin
    sram_csb1_o = '1;
    for (int unsigned b = 0; b < BANKS; b++)
      if ((p1_issue_now || p1_issue_pend) && (p1_issue_bank == 2'(b)))
        sram_csb1_o[b] = 1'b0;
    sram_addr1_o = p1_issue_now ? rd1_addr_i[7:0] : p1_word_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      p1_state    <= P1_IDLE;
      p1_bank_q   <= '0;
      p1_word_q   <= '0;
      rd1_busy_o  <= 1'b0;
      rd1_valid_o <= 1'b0;
      rd1_data_o  <= '0;
    end else begin
      case (p1_state)
        P1_IDLE: begin
          rd1_valid_o <= 1'b0;
          if (p1_start) begin
            p1_bank_q  <= rd1_addr_i[9:8];
            p1_word_q  <= rd1_addr_i[7:0];
            rd1_busy_o <= 1'b1;
            p1_state   <= p1_collide ? P1_PEND : P1_WAIT;
          end
        end
        P1_PEND: p1_state <= P1_WAIT;
        P1_WAIT: begin
          rd1_data_o  <= pick_lane(sram_dout1_i, p1_bank_q);
          rd1_valid_o <= 1'b1;
          p1_state    <= P1_DONE;
        end
        P1_DONE: begin
          rd1_valid_o <= 1'b0;
          rd1_busy_o  <= 1'b0;
          p1_state    <= P1_IDLE;
        end
        default: begin
          rd1_valid_o <= 1'b0;
          rd1_busy_o  <= 1'b0;
          p1_state    <= P1_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_bank_ctrl.sv
// Directed bench for wb_sram_bank_ctrl with two behavioural OpenRAM macros.
module tb_wb_sram_bank_ctrl;
  logic        clk;
  logic        rst_n;
  logic        rd1_req;
  logic [9:0]  rd1_addr;
  logic        rd1_busy;
  logic        rd1_valid;
  logic [31:0] rd1_data;
  logic [1:0]  csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [63:0] dout0;
  logic [1:0]  csb1;
  logic [7:0]  addr1;
  logic [63:0] dout1;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [31:0] rdata;
  int unsigned seen;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  wb_sram_bank_ctrl_if bus ();

  wb_sram_bank_ctrl #(.BANKS(2), .BASE_ADDR(32'h3000_0000)) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .wbs           (bus),
    .rd1_req_i     (rd1_req),
    .rd1_addr_i    (rd1_addr),
    .rd1_busy_o    (rd1_busy),
    .rd1_valid_o   (rd1_valid),
    .rd1_data_o    (rd1_data),
    .sram_csb0_o   (csb0),
    .sram_web0_o   (web0),
    .sram_wmask0_o (wmask0),
    .sram_addr0_o  (addr0),
    .sram_din0_o   (din0),
    .sram_dout0_i  (dout0),
    .sram_csb1_o   (csb1),
    .sram_addr1_o  (addr1),
    .sram_dout1_i  (dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: inputs sampled at the edge, dout valid through the next cycle.
  always @(posedge clk) begin
    if (!csb0[0]) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++)
          if (wmask0[i]) mem0[addr0][8*i +: 8] <= din0[8*i +: 8];
      end else dout0[31:0] <= mem0[addr0];
    end
    if (!csb0[1]) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++)
          if (wmask0[i]) mem1[addr0][8*i +: 8] <= din0[8*i +: 8];
      end else dout0[63:32] <= mem1[addr0];
    end
    if (!csb1[0]) dout1[31:0]  <= mem0[addr1];
    if (!csb1[1]) dout1[63:32] <= mem1[addr1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},    32'(bus.wbs_ack_o), 32'd0);
    check({tag, "_dat"},    bus.wbs_dat_o, 32'd0);
    check({tag, "_busy"},   32'(rd1_busy), 32'd0);
    check({tag, "_valid"},  32'(rd1_valid), 32'd0);
    check({tag, "_rd1dat"}, rd1_data, 32'd0);
    check({tag, "_csb0"},   32'(csb0), 32'd3);
    check({tag, "_csb1"},   32'(csb1), 32'd3);
    check({tag, "_web0"},   32'(web0), 32'd1);
    check({tag, "_wmask"},  32'(wmask0), 32'd0);
    check({tag, "_addr0"},  32'(addr0), 32'd0);
    check({tag, "_din0"},   din0, 32'd0);
    check({tag, "_addr1"},  32'(addr1), 32'd0);
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = a;    bus.wbs_dat_i = d;    bus.wbs_sel_i = s;
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); bus_drive(1'b1, a, d, s);
    @(negedge clk); check("wr_ack_c1", 32'(bus.wbs_ack_o), 32'd1); bus_idle();
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); bus_drive(1'b0, a, 32'd0, 4'hF);
    @(negedge clk); check("rd_noack_c1", 32'(bus.wbs_ack_o), 32'd0);
    @(negedge clk); check("rd_ack_c2", 32'(bus.wbs_ack_o), 32'd1);
    d = bus.wbs_dat_o; bus_idle();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; rd1_req = 1'b0; rd1_addr = '0;
    bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.wbs_sel_i = '0;
    bus_idle();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Write then read back bank 1 word 1
    @(negedge clk); bus_drive(1'b1, 32'h3000_0404, 32'hDEAD_BEEF, 4'hF);
    #1;
    check("wr_csb0",  32'(csb0), 32'd1);
    check("wr_web0",  32'(web0), 32'd0);
    check("wr_addr0", 32'(addr0), 32'd1);
    check("wr_din0",  din0, 32'hDEAD_BEEF);
    @(negedge clk); check("wr_ack_c1", 32'(bus.wbs_ack_o), 32'd1); bus_idle();
    @(negedge clk); check("wr_ack_one", 32'(bus.wbs_ack_o), 32'd0);
    bus_drive(1'b0, 32'h3000_0404, 32'd0, 4'hF);
    #1;
    check("rd_csb0", 32'(csb0), 32'd1);
    check("rd_web0", 32'(web0), 32'd1);
    @(negedge clk); check("rd_noack_c1", 32'(bus.wbs_ack_o), 32'd0);
    @(negedge clk); check("rd_ack_c2", 32'(bus.wbs_ack_o), 32'd1);
    check("rd_data", bus.wbs_dat_o, 32'hDEAD_BEEF);
    bus_idle();

    // Byte-masked overwrite
    wb_write(32'h3000_0010, 32'h1122_3344, 4'hF);
    wb_write(32'h3000_0010, 32'hAABB_CCDD, 4'b0101);
    wb_read(32'h3000_0010, rdata);
    check("mask_data", rdata, 32'h11BB_33DD);

    // Void bank 3 read: acked, zero data, no chip select
    @(negedge clk); bus_drive(1'b0, 32'h3000_0C00, 32'd0, 4'hF);
    #1; check("void_csb0", 32'(csb0), 32'd3);
    @(negedge clk);
    @(negedge clk); check("void_ack", 32'(bus.wbs_ack_o), 32'd1);
    check("void_data", bus.wbs_dat_o, 32'd0);
    bus_idle();

    // Out-of-window access is never acked
    @(negedge clk); bus_drive(1'b0, 32'h3001_0000, 32'd0, 4'hF);
    #1; check("miss_csb0", 32'(csb0), 32'd3);
    seen = 0;
    repeat (10) begin @(negedge clk); if (bus.wbs_ack_o) seen++; end
    check("miss_noack", seen, 32'd0);
    bus_idle();

    // Port-1 normal read of bank 1 word 1
    @(negedge clk); rd1_req = 1'b1; rd1_addr = {2'd1, 8'd1};
    #1; check("p1_csb1", 32'(csb1), 32'd1); check("p1_addr1", 32'(addr1), 32'd1);
    @(negedge clk); rd1_req = 1'b0;
    check("p1_busy_c1", 32'(rd1_busy), 32'd1); check("p1_novalid_c1", 32'(rd1_valid), 32'd0);
    @(negedge clk); check("p1_valid_c2", 32'(rd1_valid), 32'd1);
    check("p1_data", rd1_data, 32'hDEAD_BEEF);
    @(negedge clk); check("p1_busy_c3", 32'(rd1_busy), 32'd0);
    check("p1_valid_one", 32'(rd1_valid), 32'd0);

    // Port-1 void bank read
    @(negedge clk); rd1_req = 1'b1; rd1_addr = {2'd3, 8'd0};
    #1; check("p1void_csb1", 32'(csb1), 32'd3);
    @(negedge clk); rd1_req = 1'b0;
    @(negedge clk); check("p1void_valid", 32'(rd1_valid), 32'd1);
    check("p1void_data", rd1_data, 32'd0);

    // Collision: port-0 write and port-1 read of bank 0 word 5 together
    @(negedge clk);
    bus_drive(1'b1, 32'h3000_0014, 32'h0000_0005, 4'hF);
    rd1_req = 1'b1; rd1_addr = {2'd0, 8'h05};
    #1;
    check("col_csb1_c0", 32'(csb1), 32'd3);
    check("col_csb0_c0", 32'(csb0), 32'd2);
    @(negedge clk); rd1_req = 1'b0;
    check("col_wr_ack", 32'(bus.wbs_ack_o), 32'd1); bus_idle();
    check("col_busy_c1", 32'(rd1_busy), 32'd1);
    check("col_csb1_c1", 32'(csb1), 32'd2);
    @(negedge clk); check("col_busy_c2", 32'(rd1_busy), 32'd1);
    check("col_novalid_c2", 32'(rd1_valid), 32'd0);
    @(negedge clk); check("col_busy_c3", 32'(rd1_busy), 32'd1);
    check("col_valid_c3", 32'(rd1_valid), 32'd1);
    check("col_data", rd1_data, 32'h0000_0005);
    @(negedge clk); check("col_busy_c4", 32'(rd1_busy), 32'd0);

    // Drop cyc in RDWAIT, then a normal read
    @(negedge clk); bus_drive(1'b0, 32'h3000_0404, 32'd0, 4'hF);
    @(negedge clk); bus_idle();
    @(negedge clk); check("drop_noack", 32'(bus.wbs_ack_o), 32'd0);
    wb_read(32'h3000_0404, rdata);
    check("drop_next_rd", rdata, 32'hDEAD_BEEF);

    // Reset while port 0 is in RDWAIT and port 1 in P1WAIT
    @(negedge clk);
    bus_drive(1'b0, 32'h3000_0010, 32'd0, 4'hF);
    rd1_req = 1'b1; rd1_addr = {2'd0, 8'h04};
    @(negedge clk); rd1_req = 1'b0;
    rst_n = 1'b0;
    #1; check_reset_outputs("mid");
    @(negedge clk); bus_idle();
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (bus.wbs_ack_o || rd1_valid) seen++; end
    check("post_rst_quiet", seen, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
